// File: rtl/cmd_timing_gate.sv
// cmd_timing_gate: issue stage in front of cmd_handler. Holds commands until
// per-bank and global DRAM timing is met, drops illegal commands with an
// error flag, and opens a one-cycle mask bubble after every WDM.

package cmd_timing_gate_pkg;

  typedef enum logic [4:0] {
    NOP1   = 5'd0,
    ACT    = 5'd1,
    PREPB  = 5'd2,
    PREAB  = 5'd3,
    RD     = 5'd4,
    WOM    = 5'd5,
    WDM    = 5'd6,
    MACSB  = 5'd7,
    RDCP   = 5'd8,
    WRCP   = 5'd9,
    EWMUL  = 5'd10,
    REFPB  = 5'd11,
    REFAB  = 5'd12,
    WCK2CK = 5'd13,
    MRS    = 5'd14,
    LDFF   = 5'd15,
    NDME   = 5'd16,
    ACTAB  = 5'd17,
    MACAB  = 5'd18,
    AFAB   = 5'd19
  } cmd_t;

  typedef struct packed {
    logic [3:0]  bk_addr;
    logic [14:0] row;
    logic [5:0]  col;
    logic [15:0] mask;
  } pkt_t;

endpackage

module cmd_timing_gate
  import cmd_timing_gate_pkg::*;
#(
  parameter int T_RCD = 6,
  parameter int T_RAS = 14,
  parameter int T_RP  = 6,
  parameter int T_RRD = 3,
  parameter int T_CCD = 2,
  parameter int T_RFC = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  pkt_t        in_pkt,
  input  cmd_t        in_cmd,
  input  logic        intf_rdy,
  output pkt_t        pkt,
  output cmd_t        cmd,
  output logic        pkt_valid,
  output logic [15:0] bank_open,
  output logic        err_pulse,
  output logic        err_sticky
);

  localparam int NB = 16;

  // Counters are sized for the largest timing value so any load fits.
  localparam int MAX_A = (T_RCD > T_RAS) ? T_RCD : T_RAS;
  localparam int MAX_B = (T_RP > T_RRD) ? T_RP : T_RRD;
  localparam int MAX_C = (T_CCD > T_RFC) ? T_CCD : T_RFC;
  localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TMAX = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CW = $clog2(TMAX + 1);

  localparam logic [CW-1:0] LD_RCD = CW'(T_RCD - 1);
  localparam logic [CW-1:0] LD_RAS = CW'(T_RAS - 1);
  localparam logic [CW-1:0] LD_RP  = CW'(T_RP - 1);
  localparam logic [CW-1:0] LD_RRD = CW'(T_RRD - 1);
  localparam logic [CW-1:0] LD_CCD = CW'(T_CCD - 1);
  localparam logic [CW-1:0] LD_RFC = CW'(T_RFC - 1);

  typedef enum logic [2:0] {
    CLS_PASS,
    CLS_ACT,
    CLS_PRE_PB,
    CLS_PRE_AB,
    CLS_COL,
    CLS_REF_PB,
    CLS_REF_AB
  } cmd_class_t;

  typedef enum logic {
    GATE_RUN,
    GATE_BUBBLE
  } gate_state_t;

  gate_state_t state_q, state_d;

  logic [CW-1:0] rcdCnt_q [NB];
  logic [CW-1:0] rcdCnt_d [NB];
  logic [CW-1:0] rasCnt_q [NB];
  logic [CW-1:0] rasCnt_d [NB];
  logic [CW-1:0] rpCnt_q  [NB];
  logic [CW-1:0] rpCnt_d  [NB];
  logic [CW-1:0] rfcCnt_q [NB];
  logic [CW-1:0] rfcCnt_d [NB];
  logic [CW-1:0] rrdCnt_q, rrdCnt_d;
  logic [CW-1:0] ccdCnt_q, ccdCnt_d;
  logic [CW-1:0] rfcabCnt_q, rfcabCnt_d;
  logic [NB-1:0] bankOpen_q, bankOpen_d;

  pkt_t pkt_q;
  cmd_t cmd_q;
  logic pktValid_q;
  logic errPulse_q;
  logic errSticky_q;

  cmd_class_t cmdClass;
  logic [3:0] bank;
  logic       bubble;
  logic       eligible;
  logic       legal;
  logic       accept;
  logic       issue;
  logic       rasClearOpen;
  logic       rpRfcClearAll;

  assign bank      = in_pkt.bk_addr;
  assign bubble    = (state_q == GATE_BUBBLE);
  assign in_ready  = rst_n & intf_rdy & ~bubble & eligible;
  assign accept    = in_valid & in_ready;
  assign issue     = accept & legal;

  assign pkt       = pkt_q;
  assign cmd       = cmd_q;
  assign pkt_valid = pktValid_q;
  assign bank_open = bankOpen_q;
  assign err_pulse = errPulse_q;
  assign err_sticky = errSticky_q;

  // Summarise all-bank conditions needed by PREAB and REFAB eligibility.
  always_comb begin
    rasClearOpen  = 1'b1;
    rpRfcClearAll = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (bankOpen_q[i] && (rasCnt_q[i] != '0)) rasClearOpen = 1'b0;
      if ((rpCnt_q[i] != '0) || (rfcCnt_q[i] != '0)) rpRfcClearAll = 1'b0;
    end
  end

  // Classify the incoming command and decide its timing eligibility and legality.
  always_comb begin
    cmdClass = CLS_PASS;
    eligible = 1'b1;
    legal    = 1'b1;
    case (in_cmd)
      ACT:                                   cmdClass = CLS_ACT;
      PREPB:                                 cmdClass = CLS_PRE_PB;
      PREAB:                                 cmdClass = CLS_PRE_AB;
      RD, WOM, WDM, MACSB, RDCP, WRCP, EWMUL: cmdClass = CLS_COL;
      REFPB:                                 cmdClass = CLS_REF_PB;
      REFAB:                                 cmdClass = CLS_REF_AB;
      default:                               cmdClass = CLS_PASS;
    endcase
    case (cmdClass)
      CLS_ACT: begin
        eligible = (rpCnt_q[bank] == '0) && (rfcCnt_q[bank] == '0) &&
                   (rrdCnt_q == '0) && (rfcabCnt_q == '0);
        legal    = ~bankOpen_q[bank];
      end
      CLS_COL: begin
        eligible = (rcdCnt_q[bank] == '0) && (ccdCnt_q == '0) && (rfcabCnt_q == '0);
        legal    = bankOpen_q[bank];
      end
      CLS_PRE_PB: eligible = (rasCnt_q[bank] == '0);
      CLS_PRE_AB: eligible = rasClearOpen;
      CLS_REF_PB: begin
        eligible = (rpCnt_q[bank] == '0) && (rfcCnt_q[bank] == '0);
        legal    = ~bankOpen_q[bank];
      end
      CLS_REF_AB: begin
        eligible = rpRfcClearAll && (rfcabCnt_q == '0);
        legal    = (bankOpen_q == '0);
      end
      default: begin
        eligible = 1'b1;
        legal    = 1'b1;
      end
    endcase
  end

  // Counters count down to zero; an issued command reloads the ones it governs.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      rcdCnt_d[i] = (rcdCnt_q[i] == '0) ? '0 : rcdCnt_q[i] - 1'b1;
      rasCnt_d[i] = (rasCnt_q[i] == '0) ? '0 : rasCnt_q[i] - 1'b1;
      rpCnt_d[i]  = (rpCnt_q[i] == '0) ? '0 : rpCnt_q[i] - 1'b1;
      rfcCnt_d[i] = (rfcCnt_q[i] == '0) ? '0 : rfcCnt_q[i] - 1'b1;
    end
    rrdCnt_d   = (rrdCnt_q == '0) ? '0 : rrdCnt_q - 1'b1;
    ccdCnt_d   = (ccdCnt_q == '0) ? '0 : ccdCnt_q - 1'b1;
    rfcabCnt_d = (rfcabCnt_q == '0) ? '0 : rfcabCnt_q - 1'b1;
    bankOpen_d = bankOpen_q;
    if (issue) begin
      case (cmdClass)
        CLS_ACT: begin
          bankOpen_d[bank] = 1'b1;
          rcdCnt_d[bank]   = LD_RCD;
          rasCnt_d[bank]   = LD_RAS;
          rrdCnt_d         = LD_RRD;
        end
        CLS_PRE_PB: begin
          bankOpen_d[bank] = 1'b0;
          rpCnt_d[bank]    = LD_RP;
        end
        CLS_PRE_AB: begin
          bankOpen_d = '0;
          for (int i = 0; i < NB; i++) rpCnt_d[i] = LD_RP;
        end
        CLS_COL:    ccdCnt_d = LD_CCD;
        CLS_REF_PB: rfcCnt_d[bank] = LD_RFC;
        CLS_REF_AB: rfcabCnt_d = LD_RFC;
        default: ;
      endcase
    end
  end

  // Accepting a WDM opens exactly one bubble cycle for the mask transfer.
  always_comb begin
    state_d = GATE_RUN;
    if (accept && (in_cmd == WDM)) state_d = GATE_BUBBLE;
  end

  // Timing counters, bank state and the bubble state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        rcdCnt_q[i] <= '0;
        rasCnt_q[i] <= '0;
        rpCnt_q[i]  <= '0;
        rfcCnt_q[i] <= '0;
      end
      rrdCnt_q   <= '0;
      ccdCnt_q   <= '0;
      rfcabCnt_q <= '0;
      bankOpen_q <= '0;
      state_q    <= GATE_RUN;
    end else begin
      for (int i = 0; i < NB; i++) begin
        rcdCnt_q[i] <= rcdCnt_d[i];
        rasCnt_q[i] <= rasCnt_d[i];
        rpCnt_q[i]  <= rpCnt_d[i];
        rfcCnt_q[i] <= rfcCnt_d[i];
      end
      rrdCnt_q   <= rrdCnt_d;
      ccdCnt_q   <= ccdCnt_d;
      rfcabCnt_q <= rfcabCnt_d;
      bankOpen_q <= bankOpen_d;
      state_q    <= state_d;
    end
  end

  // Registered issue port and error flags toward cmd_handler.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_q       <= '0;
      cmd_q       <= NOP1;
      pktValid_q  <= 1'b0;
      errPulse_q  <= 1'b0;
      errSticky_q <= 1'b0;
    end else begin
      pktValid_q <= issue;
      if (issue) begin
        pkt_q <= in_pkt;
        cmd_q <= in_cmd;
      end
      errPulse_q <= accept & ~legal;
      if (accept && !legal) errSticky_q <= 1'b1;
    end
  end

endmodule
